// File: rtl/note_sequencer.sv
// Song player: fetches note words from memory, plays square-wave tones.
// Define NOTE_SEQUENCER_GAP_EN for a silent gap between notes.
module note_sequencer #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [7:0] mem_data,
    input  logic       mem_ready,
    input  logic [7:0] song_len,
    output logic       mem_read_en,
    output logic       mem_read_rst,
    output logic       buzzer,
    output logic [6:0] note_led,
    output logic       playing,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT, PLAY, GAP, DONE
    } state_t;

    localparam logic [31:0] BEAT = 32'(BEAT_CYCLES);
    localparam logic [31:0] ACK  = 32'(ACK_TIMEOUT);

    state_t      state;
    logic [31:0] beat_cnt;
    logic [31:0] tone_cnt;
    logic [31:0] wait_cnt;
    logic [31:0] hp_q;
    logic [31:0] len_q;
    logic [7:0]  note_idx;
    logic        rest_q;
    logic        phase;
`ifdef NOTE_SEQUENCER_GAP_EN
    localparam logic [31:0] GAPC = 32'(GAP_CYCLES);
    logic [31:0] gap_cnt;
`endif

    function automatic logic [31:0] mid_hp(input logic [3:0] n);
        case (n)
            4'd1:    mid_hp = 32'(CLK_HZ / 524);
            4'd2:    mid_hp = 32'(CLK_HZ / 588);
            4'd3:    mid_hp = 32'(CLK_HZ / 660);
            4'd4:    mid_hp = 32'(CLK_HZ / 698);
            4'd5:    mid_hp = 32'(CLK_HZ / 784);
            4'd6:    mid_hp = 32'(CLK_HZ / 880);
            4'd7:    mid_hp = 32'(CLK_HZ / 988);
            default: mid_hp = 32'd0;
        endcase
    endfunction

    logic        is_rest;
    logic [31:0] hp_mid;
    assign is_rest = (mem_data[3:0] == 4'd0) || mem_data[3];
    assign hp_mid  = mid_hp(mem_data[3:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            tone_cnt     <= '0;
            wait_cnt     <= '0;
            hp_q         <= '0;
            len_q        <= '0;
            note_idx     <= '0;
            rest_q       <= 1'b1;
            phase        <= 1'b0;
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            buzzer       <= 1'b0;
            note_led     <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
`ifdef NOTE_SEQUENCER_GAP_EN
            gap_cnt      <= '0;
`endif
        end else if (stop) begin
            state        <= IDLE;
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            buzzer       <= 1'b0;
            note_led     <= '0;
            playing      <= 1'b0;
            done         <= 1'b0;
        end else begin
            mem_read_en  <= 1'b0;
            mem_read_rst <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        note_idx <= '0;
                        if (song_len != 8'd0) begin
                            state        <= FETCH;
                            mem_read_en  <= 1'b1;
                            mem_read_rst <= 1'b1;
                            playing      <= 1'b1;
                            done         <= 1'b0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (mem_ready) begin
                        state    <= PLAY;
                        beat_cnt <= '0;
                        tone_cnt <= '0;
                        phase    <= 1'b0;
                        buzzer   <= 1'b0;
                        rest_q   <= is_rest;
                        len_q    <= BEAT << mem_data[7:6];
                        note_led <= is_rest ? 7'd0
                                    : 7'd1 << (mem_data[2:0] - 3'd1);
                        case (mem_data[5:4])
                            2'd0:    hp_q <= hp_mid << 1;
                            2'd2:    hp_q <= hp_mid >> 1;
                            default: hp_q <= hp_mid;
                        endcase
                    end else if (wait_cnt == ACK - 32'd1) begin
                        state   <= DONE;
                        playing <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                PLAY: begin
                    if (pause) begin
                        buzzer <= 1'b0;
                    end else if (beat_cnt == len_q - 32'd1) begin
                        buzzer   <= 1'b0;
                        note_led <= '0;
                        note_idx <= note_idx + 8'd1;
                        if (note_idx + 8'd1 == song_len) begin
                            state   <= DONE;
                            playing <= 1'b0;
                            done    <= 1'b1;
                        end else begin
`ifdef NOTE_SEQUENCER_GAP_EN
                            state   <= GAP;
                            gap_cnt <= '0;
`else
                            state       <= FETCH;
                            mem_read_en <= 1'b1;
`endif
                        end
                    end else begin
                        beat_cnt <= beat_cnt + 32'd1;
                        // phase keeps the tone position across pauses
                        if (tone_cnt == hp_q - 32'd1) begin
                            tone_cnt <= '0;
                            phase    <= ~phase;
                            buzzer   <= ~phase & ~rest_q;
                        end else begin
                            tone_cnt <= tone_cnt + 32'd1;
                            buzzer   <= phase & ~rest_q;
                        end
                    end
                end
`ifdef NOTE_SEQUENCER_GAP_EN
                GAP: begin
                    buzzer <= 1'b0;
                    if (!pause) begin
                        if (gap_cnt == GAPC - 32'd1) begin
                            state       <= FETCH;
                            mem_read_en <= 1'b1;
                        end else begin
                            gap_cnt <= gap_cnt + 32'd1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: random songs against a tone/timing model.
module tb_note_sequencer;

    localparam int CLK_HZ = 20_000;
    localparam int BEAT   = 100;
    localparam int GAPC   = 10;
    localparam int ACK    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] mem_data = 8'd0;
    logic       mem_ready = 1'b0;
    logic [7:0] song_len = 8'd0;
    logic       mem_read_en;
    logic       mem_read_rst;
    logic       buzzer;
    logic [6:0] note_led;
    logic       playing;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] song [256];
    int         rd_ptr = 0;
    bit         mem_en = 1'b1;

    note_sequencer #(
        .CLK_HZ(CLK_HZ),
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES(GAPC),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .pause(pause),
        .stop(stop),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .song_len(song_len),
        .mem_read_en(mem_read_en),
        .mem_read_rst(mem_read_rst),
        .buzzer(buzzer),
        .note_led(note_led),
        .playing(playing),
        .done(done)
    );

    always #5 clk = ~clk;

    // memory: one-cycle latency responder with rewindable pointer
    always @(posedge clk) begin
        if (mem_en && mem_read_en) begin
            mem_ready <= 1'b1;
            mem_data  <= mem_read_rst ? song[0] : song[rd_ptr[7:0]];
            rd_ptr    <= (mem_read_rst ? 0 : rd_ptr) + 1;
        end else begin
            mem_ready <= 1'b0;
            if (mem_read_rst) rd_ptr <= 0;
        end
    end

    function automatic int freq(input int n);
        int f [7] = '{262, 294, 330, 349, 392, 440, 494};
        return f[n - 1];
    endfunction

    function automatic int hp_of(input logic [7:0] w);
        int n;
        int hp;
        n = int'(w[3:0]);
        if (n == 0 || n > 7) return 0;
        hp = CLK_HZ / (2 * freq(n));
        if (w[5:4] == 2'd0) hp = hp * 2;
        else if (w[5:4] == 2'd2) hp = hp / 2;
        return hp;
    endfunction

    function automatic logic [6:0] led_of(input logic [7:0] w);
        int n;
        n = int'(w[3:0]);
        if (n == 0 || n > 7) return 7'd0;
        return 7'(1 << (n - 1));
    endfunction

    function automatic logic exp_buzz(input logic [7:0] w, input int k);
        int hp;
        hp = hp_of(w);
        if (hp == 0) return 1'b0;
        return 1'((k / hp) % 2);
    endfunction

    function automatic int len_of(input logic [7:0] w);
        return BEAT * (1 << int'(w[7:6]));
    endfunction

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk) stop = 1'b1;
        @(negedge clk) stop = 1'b0;
    endtask

    task automatic run_song(input int n, input int pnote,
                            input int pat, input bit poke);
        int         t;
        int         len;
        logic [7:0] w;
        logic       eb;
        logic [6:0] el;
        song_len = 8'(n);
        do_start();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (mem_read_en !== 1'b1 || mem_read_rst !== (i == 0)) begin
                n_bad++;
                $display("FAIL fetch[%0d]: rd_en=%b rd_rst=%b want 1/%b",
                         i, mem_read_en, mem_read_rst, i == 0);
            end
            t = 0;
            while (mem_ready !== 1'b1 && t < 20) begin
                @(negedge clk);
                t++;
            end
            n_cmp++;
            if (t >= 20) begin
                n_bad++;
                $display("FAIL mem_wait[%0d]: no mem_ready within 20", i);
                return;
            end
            w   = song[i];
            len = len_of(w);
            el  = led_of(w);
            for (int k = 0; k < len; k++) begin
                @(negedge clk);
                eb = exp_buzz(w, k);
                n_cmp++;
                if ({buzzer, note_led, playing, done} !==
                    {eb, el, 1'b1, 1'b0}) begin
                    n_bad++;
                    if (n_bad <= 20)
                        $display("FAIL play[%0d] k=%0d: bz=%b led=%h pl=%b dn=%b want %b %h 1 0",
                                 i, k, buzzer, note_led, playing, done, eb, el);
                end
                if (poke && i == 0) start = (k == 2);
                if (i == pnote && k == pat) begin
                    pause = 1'b1;
                    repeat (30) begin
                        @(negedge clk);
                        n_cmp++;
                        if ({buzzer, note_led, playing} !== {1'b0, el, 1'b1}) begin
                            n_bad++;
                            if (n_bad <= 20)
                                $display("FAIL pause[%0d]: bz=%b led=%h pl=%b want 0 %h 1",
                                         i, buzzer, note_led, playing, el);
                        end
                    end
                    pause = 1'b0;
                end
            end
            @(negedge clk);
            if (i == n - 1) begin
                n_cmp++;
                if ({done, playing, buzzer, note_led} !== {1'b1, 1'b0, 1'b0, 7'd0}) begin
                    n_bad++;
                    $display("FAIL song_end: dn=%b pl=%b bz=%b led=%h want 1 0 0 00",
                             done, playing, buzzer, note_led);
                end
            end else begin
`ifdef NOTE_SEQUENCER_GAP_EN
                for (int g = 0; g < GAPC; g++) begin
                    n_cmp++;
                    if ({mem_read_en, buzzer, playing, note_led} !==
                        {1'b0, 1'b0, 1'b1, 7'd0}) begin
                        n_bad++;
                        $display("FAIL gap[%0d] g=%0d: rd=%b bz=%b pl=%b led=%h want 0 0 1 00",
                                 i, g, mem_read_en, buzzer, playing, note_led);
                    end
                    @(negedge clk);
                end
`endif
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({buzzer, mem_read_en, mem_read_rst, playing, done, note_led} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset: outputs=%b want 0", {buzzer, mem_read_en,
                     mem_read_rst, playing, done, note_led});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({playing, done, mem_read_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle: pl=%b dn=%b rd=%b want 0 0 0", playing, done, mem_read_en);
        end
    endtask

    task automatic test_directed();
        song[0] = 8'h16;
        song[1] = 8'h40;
        run_song(2, -1, 0, 1'b0);
        do_stop();
    endtask

    task automatic test_random();
        int n;
        for (int s = 0; s < 3; s++) begin
            n = int'($urandom_range(2, 5));
            for (int i = 0; i < n; i++)
                song[i] = {2'($urandom_range(0, 2)), 2'($urandom), 4'($urandom)};
            run_song(n, int'($urandom_range(0, n - 1)),
                     int'($urandom_range(0, 99)), s[0]);
        end
    endtask

    task automatic test_empty();
        do_stop();
        song_len = 8'd0;
        do_start();
        n_cmp++;
        if ({done, playing, mem_read_en, mem_read_rst} !== 4'b1000) begin
            n_bad++;
            $display("FAIL empty: dn=%b pl=%b rd=%b rr=%b want 1 0 0 0",
                     done, playing, mem_read_en, mem_read_rst);
        end
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if ({done, mem_read_en} !== 2'b10) begin
                n_bad++;
                $display("FAIL empty_hold: dn=%b rd=%b want 1 0", done, mem_read_en);
            end
        end
    endtask

    task automatic test_timeout();
        do_stop();
        mem_en   = 1'b0;
        song_len = 8'd1;
        do_start();
        for (int j = 0; j < ACK; j++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, playing} !== 2'b01) begin
                n_bad++;
                $display("FAIL timeout_wait j=%0d: dn=%b pl=%b want 0 1", j, done, playing);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({done, playing} !== 2'b10) begin
            n_bad++;
            $display("FAIL timeout_done: dn=%b pl=%b want 1 0", done, playing);
        end
        mem_en = 1'b1;
    endtask

    task automatic test_stop_start();
        int t;
        do_stop();
        song[0]  = 8'h05;
        song_len = 8'd3;
        do_start();
        t = 0;
        while (mem_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        stop  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        start = 1'b0;
        n_cmp++;
        if ({playing, done, buzzer, note_led, mem_read_en} !== 11'd0) begin
            n_bad++;
            $display("FAIL stop_start: pl=%b dn=%b bz=%b led=%h rd=%b want all 0",
                     playing, done, buzzer, note_led, mem_read_en);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({playing, mem_read_en} !== 2'b00) begin
            n_bad++;
            $display("FAIL stop_idle: pl=%b rd=%b want 0 0", playing, mem_read_en);
        end
    endtask

    task automatic test_reset_mid();
        int t;
        song[0]  = 8'h97;
        song_len = 8'd2;
        do_start();
        t = 0;
        while (mem_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({buzzer, mem_read_en, mem_read_rst, playing, done, note_led} !== 12'd0) begin
            n_bad++;
            $display("FAIL reset_mid: outputs=%b want 0", {buzzer, mem_read_en,
                     mem_read_rst, playing, done, note_led});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_cmp++;
            if ({playing, mem_read_en, buzzer} !== 3'b000) begin
                n_bad++;
                $display("FAIL reset_idle: pl=%b rd=%b bz=%b want 0 0 0",
                         playing, mem_read_en, buzzer);
            end
        end
    endtask

    task automatic test_long_song();
        for (int i = 0; i < 255; i++)
            song[i] = {2'b00, 2'($urandom), 4'($urandom)};
        run_song(255, -1, 0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_empty();
        test_random();
        test_timeout();
        test_stop_start();
        test_reset_mid();
        test_long_song();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
